// File: rtl/fp_pkg.sv
// Shared definitions for the FP accumulator: word layout, zero constant, FSM encoding.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned FP_W   = 1 + EXP_W + MANT_W;

    typedef logic [FP_W-1:0] fpWord_t;

    localparam fpWord_t FP_ZERO = '0;

    // Accumulator FSM state; fixed encodings kept for compatibility with older tooling.
    typedef logic [1:0] accState_t;

    localparam accState_t ST_IDLE  = 2'd0;
    localparam accState_t ST_ACCUM = 2'd1;
    localparam accState_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/fp_accum_seq_if.sv
// Operand stream, external-adder link and result handshake of the FP accumulator.
interface fp_accum_seq_if #(
    parameter int unsigned CNT_W = 16
);
    import fp_pkg::*;

    // operand stream
    logic             in_valid;
    logic             in_ready;
    fpWord_t          in_data;
    logic             in_last;

    // external combinational adder
    fpWord_t          add_a;
    fpWord_t          add_b;
    fpWord_t          add_c;
    logic             add_ov;

    // result
    logic             out_valid;
    logic             out_ready;
    fpWord_t          out_sum;
    logic             out_ov;
    logic [CNT_W-1:0] out_count;

    // environment side: produces operands and adder results, consumes sums
    modport master (
        output in_valid, in_data, in_last,
        output add_c, add_ov,
        output out_ready,
        input  in_ready,
        input  add_a, add_b,
        input  out_valid, out_sum, out_ov, out_count
    );

    // accumulator side
    modport slave (
        input  in_valid, in_data, in_last,
        input  add_c, add_ov,
        input  out_ready,
        output in_ready,
        output add_a, add_b,
        output out_valid, out_sum, out_ov, out_count
    );

endinterface

// File: rtl/fp_accum_seq.sv
// Streaming IEEE-754 single accumulator: sums beats up to in_last using an
// external combinational adder, then holds the result until it is taken.
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    fp_accum_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] COUNT_MAX = '1;
    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

    accState_t        state;
    accState_t        stateNext;
    fpWord_t          accReg;
    logic [CNT_W-1:0] countReg;
    logic             ovSticky;
    logic             accept;

    assign accept = bus.in_valid && (state != ST_HOLD);

    // Next-state: collect beats until in_last, then hold until the result is read.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    stateNext = bus.in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State register; reset discards any partial or unread sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath: first beat loads directly, later beats take the adder result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accReg   <= FP_ZERO;
            countReg <= '0;
            ovSticky <= 1'b0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                accReg   <= bus.in_data;
                countReg <= COUNT_ONE;
                ovSticky <= 1'b0;
            end else begin
                accReg   <= bus.add_c;
                ovSticky <= ovSticky | bus.add_ov;
                if (countReg != COUNT_MAX) begin
                    countReg <= countReg + 1'b1;
                end
            end
        end
    end

    // Outputs: adder operands are always live; result is valid only while holding.
    always_comb begin
        bus.in_ready  = (state != ST_HOLD);
        bus.add_a     = accReg;
        bus.add_b     = bus.in_data;
        bus.out_valid = (state == ST_HOLD);
        bus.out_sum   = accReg;
        bus.out_ov    = ovSticky;
        bus.out_count = countReg;
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq: directed scenarios plus randomized sums
// checked every cycle against a beat-level reference model.
module tb_fp_accum_seq;
    import fp_pkg::*;

    localparam int unsigned CW  = 4;
    localparam int unsigned CAP = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic forceOv;
    logic [32:0] adderRes;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          holding;
    bit          inSum;
    bit          expOv;
    bit          lastAccept;
    logic [31:0] expAcc;
    int unsigned expCount;

    fp_accum_seq_if #(.CNT_W(CW)) bus ();

    fp_accum_seq #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic real toReal(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // {overflow, single}; truncating conversion, flush to zero on underflow
    function automatic logic [32:0] fromReal(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return 33'd0;
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        return {1'b0, d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [32:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
        return fromReal(toReal(a) + toReal(b));
    endfunction

    function automatic logic [31:0] randFp();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(120, 134));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    function automatic logic [31:0] capCount(input int unsigned n);
        return (n > CAP) ? 32'(CAP) : 32'(n);
    endfunction

    // external adder seen by the DUT
    always_comb adderRes = fpAdd(bus.add_a, bus.add_b);
    assign bus.add_c  = adderRes[31:0];
    assign bus.add_ov = adderRes[32] | forceOv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        holding  = 1'b0;
        inSum    = 1'b0;
        expOv    = 1'b0;
        expAcc   = 32'd0;
        expCount = 0;
    endtask

    // One clock: check all outputs at negedge, advance the model, return at posedge+1.
    task automatic cycle();
        logic [32:0] r;
        bit acceptNow;
        @(negedge clk);
        chk("in_ready",  32'(bus.in_ready),  32'(!holding));
        chk("out_valid", 32'(bus.out_valid), 32'(holding));
        chk("add_a",     bus.add_a,          expAcc);
        chk("add_b",     bus.add_b,          bus.in_data);
        chk("out_sum",   bus.out_sum,        expAcc);
        chk("out_ov",    32'(bus.out_ov),    32'(expOv));
        chk("out_count", 32'(bus.out_count), capCount(expCount));
        acceptNow  = bus.in_valid && !holding;
        lastAccept = acceptNow;
        if (holding && bus.out_ready) holding = 1'b0;
        if (acceptNow) begin
            if (!inSum) begin
                expAcc   = bus.in_data;
                expCount = 1;
                expOv    = 1'b0;
            end else begin
                r        = fpAdd(expAcc, bus.in_data);
                expAcc   = r[31:0];
                expOv    = expOv | r[32] | forceOv;
                expCount = expCount + 1;
            end
            inSum   = !bus.in_last;
            holding = bus.in_last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic last);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = last;
    endtask

    task automatic offerBeat(input logic [31:0] d, input logic last);
        bit done;
        done = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, randFp(), 1'($urandom_range(0, 1)));
            forceOv = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drive(1'b1, d, last);
        forceOv = ($urandom_range(0, 9) == 0);
        for (int k = 0; k < 64 && !done; k++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
            done = lastAccept;
        end
        bus.in_valid = 1'b0;
        forceOv = 1'b0;
        chk("beat_timeout", 32'(done), 32'd1);
    endtask

    task automatic runSum(input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            offerBeat(randFp(), (i == len - 1));
        end
    endtask

    task automatic resetPulse();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   bus.out_sum,        32'h0000_0000);
        chk("rst_out_ov",    32'(bus.out_ov),    32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit drained;
        drive(1'b0, 32'd0, 1'b0);
        bus.out_ready = 1'b0;
        forceOv = 1'b0;
        modelReset();
        lastAccept = 1'b0;

        // reset values while rst_n is held low
        #1;
        chk("rst0_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst0_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst0_out_sum",   bus.out_sum,        32'h0000_0000);
        chk("rst0_out_ov",    32'(bus.out_ov),    32'd0);
        chk("rst0_out_count", 32'(bus.out_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1.0 + 2.0 + 3.0 = 6.0, result valid the cycle after the last beat
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h3F80_0000, 1'b0); cycle();
        drive(1'b1, 32'h4000_0000, 1'b0); cycle();
        drive(1'b1, 32'h4040_0000, 1'b1); cycle();
        drive(1'b0, 32'h0, 1'b0);
        chk("sum6_valid", 32'(bus.out_valid), 32'd1);
        chk("sum6_sum",   bus.out_sum,        32'h40C0_0000);
        chk("sum6_count", 32'(bus.out_count), 32'd3);
        chk("sum6_ov",    32'(bus.out_ov),    32'd0);
        cycle();
        chk("sum6_idle", 32'(bus.in_ready), 32'd1);

        // single beat bypasses the adder; add_ov ignored on it
        forceOv = 1'b1;
        drive(1'b1, 32'h4020_0000, 1'b1); cycle();
        forceOv = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("single_sum",   bus.out_sum,        32'h4020_0000);
        chk("single_count", 32'(bus.out_count), 32'd1);
        chk("single_ov",    32'(bus.out_ov),    32'd0);
        cycle();

        // 1.5 + 2.5 held for three cycles with stalled incoming beats
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h3FC0_0000, 1'b0); cycle();
        drive(1'b1, 32'h4020_0000, 1'b1); cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, randFp(), 1'b0);
            cycle();
            chk("hold_sum",   bus.out_sum,        32'h4080_0000);
            chk("hold_ready", 32'(bus.in_ready),  32'd0);
        end
        drive(1'b0, 32'h0, 1'b0);
        bus.out_ready = 1'b1;
        cycle();
        chk("hold_rel_ready", 32'(bus.in_ready),  32'd1);
        chk("hold_rel_valid", 32'(bus.out_valid), 32'd0);

        // 17 zero beats saturate the 4-bit count at 15
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 32'h0, (k == 16));
            cycle();
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("sat_count", 32'(bus.out_count), 32'd15);
        chk("sat_sum",   bus.out_sum,        32'h0000_0000);
        cycle();

        // adder overflow on beat 2 of 4 is sticky
        for (int k = 0; k < 4; k++) begin
            forceOv = (k == 1);
            drive(1'b1, 32'h3F80_0000, (k == 3));
            cycle();
        end
        forceOv = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("ov_sticky", 32'(bus.out_ov),    32'd1);
        chk("ov_sum",    bus.out_sum,        32'h4080_0000);
        cycle();

        // reset two beats into a sum, then a fresh sum must be clean
        drive(1'b1, randFp(), 1'b0); cycle();
        drive(1'b1, randFp(), 1'b0); cycle();
        resetPulse();
        runSum(5);

        // randomized sums with bubbles, stalls, spurious overflow and back-pressure
        for (int s = 0; s < 30; s++) begin
            runSum($urandom_range(1, 20));
            if ($urandom_range(0, 9) == 0) resetPulse();
        end

        // drain the final result
        drive(1'b0, 32'h0, 1'b0);
        bus.out_ready = 1'b1;
        drained = 1'b0;
        for (int k = 0; k < 8 && !drained; k++) begin
            cycle();
            drained = !holding;
        end
        chk("drain_timeout", 32'(drained), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_accum_seq.md
FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, element-count width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand beat valid.
REQ-005 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-006 SHALL have port in_data  input  32  IEEE-754 single operand.
REQ-007 SHALL have port in_last  input  1  final beat of current sum.
REQ-008 SHALL have port add_a  output  32  operand A to external combinational FP adder.
REQ-009 SHALL have port add_b  output  32  operand B to external combinational FP adder.
REQ-010 SHALL have port add_c  input  32  adder result, same cycle.
REQ-011 SHALL have port add_ov  input  1  adder exponent-overflow flag, same cycle.
REQ-012 SHALL have port out_valid  output  1  sum result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_sum  output  32  accumulated sum.
REQ-015 SHALL have port out_ov  output  1  sticky overflow over the whole sum.
REQ-016 SHALL have port out_count  output  CNT_W  beats summed, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-018 Beat accepted iff in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD.
REQ-019 IDLE accept: acc <= in_data (bypasses adder), count <= 1, ov_sticky <= 0; next = HOLD if in_last, else ACCUM.
REQ-020 ACCUM accept: acc <= add_c, ov_sticky <= ov_sticky | add_ov, count <= count+1; next = HOLD if in_last, else ACCUM.
REQ-021 No accept in IDLE/ACCUM: all registers and state held (bubbles allowed indefinitely).
REQ-022 add_a SHALL equal acc and add_b SHALL equal in_data combinationally in every state.
REQ-023 out_valid SHALL be 1 exactly in HOLD; out_sum = acc, out_ov = ov_sticky, out_count = count.
REQ-024 HOLD && out_ready: next = IDLE; outputs stable while out_ready low.
REQ-025 Latency: out_valid rises the cycle after the in_last beat is accepted; throughput one beat per cycle.
REQ-026 count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 add_ov is sampled only on accepted ACCUM beats; ignored otherwise.
REQ-028 Beats arriving in HOLD are not accepted (stall); no overlap of consecutive sums.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, acc 0, count 0, ov_sticky 0.
REQ-030 Reset values: in_ready 1, out_valid 0, out_sum 0x00000000, out_ov 0, out_count 0.
REQ-031 Reset mid-sum or in HOLD SHALL discard partial/unread result; first beat after release starts a new sum.

Structure
REQ-032 Shared package fp_pkg SHALL hold the FSM state typedef, FP_ZERO (0x00000000) and field-width constants (EXP_W 8, MANT_W 23).
REQ-033 Adder SHALL stay external, connected via add_*; no sub-module inside this block.

Verification
REQ-034 Beats 1.0, 2.0, 3.0 (0x3F800000, 0x40000000, 0x40400000; last on third), out_ready=1 -> out_sum 0x40C00000, out_count 3, out_ov 0, out_valid one cycle after third beat.
REQ-035 Single beat 0x40200000 with in_last -> out_sum 0x40200000, out_count 1; adder output unused.
REQ-036 Beats 1.5, 2.5 with out_ready held low 3 cycles -> out_sum 0x40800000 stable, in_ready 0 throughout, IDLE after handshake.
REQ-037 CNT_W=4, 17 beats of 0x00000000 -> out_count 15 (saturated).
REQ-038 Adder model asserting add_ov on beat 2 of 4 -> out_ov 1; rst_n pulsed low after beat 2 of a new sum -> out_valid 0, out_count 0, next sum correct.
